// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic        valid_q,
    output logic [31:0] instr_q,
    output logic [31:0] pc4_q
);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, stall hold buffer,
// redirect with kill of stale responses, and IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc4_o,
    output logic        misalign_o
);

    fetch_state_t state;
    logic [31:0]  pc, pend_pc, hold_instr, hold_pc4;
    logic         kill;
    logic         load, flush, granted, outstanding;
    logic [31:0]  ld_instr, ld_pc4;

    always_comb begin
        imem_req_o = 1'b0;
        load       = 1'b0;
        ld_instr   = imem_rdata_i;
        ld_pc4     = pend_pc + 32'd4;
        case (state)
            FETCH: imem_req_o = 1'b1;
            WAIT: if (imem_rvalid_i && !kill && !stall_i) begin
                imem_req_o = 1'b1;
                load       = 1'b1;
            end
            HOLD: if (!stall_i) begin
                load     = 1'b1;
                ld_instr = hold_instr;
                ld_pc4   = hold_pc4;
            end
            default: ;
        endcase
        // A redirect never issues at the stale PC, so it can't create a grant to kill.
        if (!rst || redirect_i) begin
            imem_req_o = 1'b0;
            load       = 1'b0;
        end
    end

    assign granted     = imem_req_o && imem_gnt_i;
    assign outstanding = (state == WAIT) && !imem_rvalid_i;
    // Unstalled cycles with nothing new become bubbles so decode never sees a repeat.
    assign flush       = redirect_i || (!load && !stall_i);
    assign imem_addr_o = pc;
    assign if_pc_o     = pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= {RESET_PC[31:2], 2'b00};
            pend_pc    <= 32'h0;
            kill       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                pc         <= {redirect_pc_i[31:2], 2'b00};
                hold_instr <= NOP_INSTR;
                hold_pc4   <= 32'h0;
                kill       <= outstanding || granted;
                state      <= (outstanding || granted) ? WAIT : FETCH;
            end else begin
                case (state)
                    FETCH: if (granted) begin
                        pend_pc <= pc;
                        pc      <= pc + 32'd4;
                        state   <= WAIT;
                    end
                    WAIT: if (imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= FETCH;
                        end else if (stall_i) begin
                            hold_instr <= imem_rdata_i;
                            hold_pc4   <= pend_pc + 32'd4;
                            state      <= HOLD;
                        end else if (granted) begin
                            pend_pc <= pc;
                            pc      <= pc + 32'd4;
                        end else begin
                            state <= FETCH;
                        end
                    end
                    HOLD: if (!stall_i) state <= FETCH;
                    default: state <= FETCH;
                endcase
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (load),
        .instr_d (ld_instr),
        .pc4_d   (ld_pc4),
        .valid_q (id_valid_o),
        .instr_q (id_instr_o),
        .pc4_q   (id_pc4_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction memory model (word = 0x20080001 + addr/4).
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] if_pc_o, id_instr_o, id_pc4_o;
    logic        id_valid_o, misalign_o;

    int errors = 0;
    int checks = 0;

    int          gnt_dly = 0;
    int          rv_dly  = 1;
    int          req_wait, rcnt;
    logic        mem_out;
    logic [31:0] rsp_addr;
    int          proto_err = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_pc_o       (if_pc_o),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc4_o      (id_pc4_o),
        .misalign_o    (misalign_o)
    );

    // Memory: grant after gnt_dly cycles of continuous request, respond rv_dly cycles after grant.
    assign imem_gnt_i    = imem_req_o && (req_wait >= gnt_dly);
    assign imem_rvalid_i = mem_out && (rcnt == 0);
    assign imem_rdata_i  = 32'h2008_0001 + (rsp_addr >> 2);

    always @(posedge clk) begin
        if (!rst) begin
            mem_out  <= 1'b0;
            rcnt     <= 0;
            req_wait <= 0;
            rsp_addr <= 32'h0;
        end else begin
            if (imem_rvalid_i) mem_out <= 1'b0;
            else if (mem_out) rcnt <= rcnt - 1;
            if (imem_req_o && imem_gnt_i) begin
                mem_out  <= 1'b1;
                rcnt     <= rv_dly - 1;
                rsp_addr <= imem_addr_o;
                req_wait <= 0;
            end else if (imem_req_o) begin
                req_wait <= req_wait + 1;
            end else begin
                req_wait <= 0;
            end
        end
    end

    // Protocol watch: alignment, if_pc tracking, address stability, single outstanding.
    always @(negedge clk) begin
        if (rst) begin
            if (imem_req_o && (imem_addr_o[1:0] != 2'b00 || if_pc_o != imem_addr_o))
                proto_err <= proto_err + 1;
            if (prev_pend && imem_req_o && imem_addr_o != prev_addr)
                proto_err <= proto_err + 1;
            if (imem_req_o && imem_gnt_i && mem_out && !imem_rvalid_i)
                proto_err <= proto_err + 1;
        end
        prev_pend <= rst && imem_req_o && !imem_gnt_i && !redirect_i;
        prev_addr <= imem_addr_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int gd, input int rd);
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        gnt_dly = gd; rv_dly = rd;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int maxc, output logic got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            if (id_valid_o === 1'b1) got = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        step();
        step();
        #1;
        checks += 6;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
        if (id_instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", id_instr_o); end
        if (id_pc4_o !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", id_pc4_o); end
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
        if (if_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc_o); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b want 1", imem_req_o); end
        if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %h want 0", imem_addr_o); end
    endtask

    task automatic test_fetch();
        reset_dut(0, 1);
        step();
        checks++;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_c2_valid: got %b want 0", id_valid_o); end
        step();
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (id_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d]: got %b want 1", k, id_valid_o); end
            if (id_pc4_o !== 32'(4 * (k + 1))) begin errors++; $display("FAIL fetch_pc4[%0d]: got %h want %h", k, id_pc4_o, 4 * (k + 1)); end
            if (id_instr_o !== 32'h2008_0001 + 32'(k)) begin errors++; $display("FAIL fetch_instr[%0d]: got %h want %h", k, id_instr_o, 32'h2008_0001 + 32'(k)); end
            step();
        end
    endtask

    task automatic test_stall();
        reset_dut(0, 1);
        repeat (4) step();
        checks++;
        if (id_pc4_o !== 32'd12) begin errors++; $display("FAIL stall_pre_pc4: got %h want c", id_pc4_o); end
        step();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 3;
            if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req_o); end
            if (id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, id_valid_o); end
            if (id_pc4_o !== 32'd16) begin errors++; $display("FAIL stall_pc4[%0d]: got %h want 10", k, id_pc4_o); end
            step();
        end
        stall_i = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold_req: got %b want 0", imem_req_o); end
        step();
        checks += 4;
        if (id_pc4_o !== 32'd20) begin errors++; $display("FAIL stall_rel_pc4: got %h want 14", id_pc4_o); end
        if (id_instr_o !== 32'h2008_0005) begin errors++; $display("FAIL stall_rel_instr: got %h want 20080005", id_instr_o); end
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_rel_req: got %b want 1", imem_req_o); end
        if (imem_addr_o !== 32'd20) begin errors++; $display("FAIL stall_rel_addr: got %h want 14", imem_addr_o); end
        step();
        checks++;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b want 0", id_valid_o); end
        step();
        checks += 2;
        if (id_pc4_o !== 32'd24) begin errors++; $display("FAIL stall_next_pc4: got %h want 18", id_pc4_o); end
        if (id_instr_o !== 32'h2008_0006) begin errors++; $display("FAIL stall_next_instr: got %h want 20080006", id_instr_o); end
    endtask

    task automatic test_redirect_kill();
        logic got;
        reset_dut(0, 3);
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL kill_redir_req: got %b want 0", imem_req_o); end
        step();
        redirect_i = 1'b0;
        #1;
        checks += 3;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL kill_wait_req: got %b want 0", imem_req_o); end
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL kill_wait_valid: got %b want 0", id_valid_o); end
        if (if_pc_o !== 32'h100) begin errors++; $display("FAIL kill_pc: got %h want 100", if_pc_o); end
        step();
        checks += 2;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop_valid: got %b want 0", id_valid_o); end
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL kill_drop_req: got %b want 0", imem_req_o); end
        step();
        checks += 2;
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL kill_refetch_req: got %b want 1", imem_req_o); end
        if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL kill_refetch_addr: got %h want 100", imem_addr_o); end
        step();
        wait_valid(10, got);
        checks += 3;
        if (got !== 1'b1) begin errors++; $display("FAIL kill_timeout: got %b want 1", got); end
        if (id_pc4_o !== 32'h104) begin errors++; $display("FAIL kill_pc4: got %h want 104", id_pc4_o); end
        if (id_instr_o !== 32'h2008_0041) begin errors++; $display("FAIL kill_instr: got %h want 20080041", id_instr_o); end
    endtask

    task automatic test_redirect_stall();
        reset_dut(0, 1);
        step();
        step();
        checks++;
        if (id_pc4_o !== 32'd4) begin errors++; $display("FAIL rs_pre_pc4: got %h want 4", id_pc4_o); end
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rs_req: got %b want 0", imem_req_o); end
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        #1;
        checks += 4;
        if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b want 0", id_valid_o); end
        if (id_instr_o !== 32'h0) begin errors++; $display("FAIL rs_instr: got %h want 0", id_instr_o); end
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rs_fetch_req: got %b want 1", imem_req_o); end
        if (imem_addr_o !== 32'h40) begin errors++; $display("FAIL rs_fetch_addr: got %h want 40", imem_addr_o); end
        step();
        step();
        checks += 2;
        if (id_pc4_o !== 32'h44) begin errors++; $display("FAIL rs_pc4: got %h want 44", id_pc4_o); end
        if (id_instr_o !== 32'h2008_0011) begin errors++; $display("FAIL rs_instr2: got %h want 20080011", id_instr_o); end
    endtask

    task automatic test_misalign();
        reset_dut(0, 1);
        checks++;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pre: got %b want 0", misalign_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        step();
        redirect_i = 1'b0;
        #1;
        checks += 3;
        if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign_o); end
        if (imem_req_o !== 1'b1) begin errors++; $display("FAIL mis_req: got %b want 1", imem_req_o); end
        if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL mis_addr: got %h want 200", imem_addr_o); end
        step();
        checks++;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", misalign_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        #1;
        checks += 2;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_aligned: got %b want 0", misalign_o); end
        if (imem_addr_o !== 32'h300) begin errors++; $display("FAIL mis_addr2: got %h want 300", imem_addr_o); end
    endtask

    task automatic test_wrap_delay();
        logic got;
        reset_dut(2, 3);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i = 1'b0;
        #1;
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr: got %h want fffffff8", imem_addr_o); end
        wait_valid(20, got);
        checks += 3;
        if (got !== 1'b1) begin errors++; $display("FAIL wrap_timeout1: got %b want 1", got); end
        if (id_pc4_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc4_1: got %h want fffffffc", id_pc4_o); end
        if (id_instr_o !== 32'h6007_FFFF) begin errors++; $display("FAIL wrap_instr1: got %h want 6007ffff", id_instr_o); end
        step();
        wait_valid(20, got);
        checks += 4;
        if (got !== 1'b1) begin errors++; $display("FAIL wrap_timeout2: got %b want 1", got); end
        if (id_pc4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4_2: got %h want 0", id_pc4_o); end
        if (id_instr_o !== 32'h6008_0000) begin errors++; $display("FAIL wrap_instr2: got %h want 60080000", id_instr_o); end
        if (proto_err !== 0) begin errors++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_kill();
        test_redirect_stall();
        test_misalign();
        test_wrap_delay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
